byte_load_ctrl: RTL and testbench
=================================

# byte_load_ctrl

Multi-cycle controller for byte loads (LB / LBU) in the 16-bit datapath. It accepts a load request, reads the aligned 16-bit word from data memory under a stall handshake, selects the addressed byte, and drives the shared 8-to-16 byte extender (8-bit input, sign/zero select, 16-bit output). It then registers the extended result and signals completion. It sits between the memory stage and data memory, and owns the extender's input and sign-select lines.

## Interface
- MAX_WAIT, default 16: maximum consecutive stall cycles tolerated in REQ before a timeout error (valid range 1–255).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled only in IDLE
- addr  in  16  byte address of the load
- sign  in  1  1 = LB (sign-extend), 0 = LBU (zero-extend)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = memory error or timeout
- data_out  out  16  extended load result, held until next done
- mem_rd  out  1  memory read enable
- mem_addr  out  16  word-aligned address, {addr_q[15:1],1'b0}
- mem_stall  in  1  memory not ready this cycle
- mem_err  in  1  memory fault, meaningful when mem_rd=1
- mem_data  in  16  read data, valid when mem_rd=1 and mem_stall=0
- ext_in  out  8  byte to the extender
- ext_sign  out  1  sign select to the extender
- ext_out  in  16  extender result

## Operation
- **Reset values:** state=IDLE, busy=0, done=0, err=0, data_out=16'h0000, mem_rd=0, mem_addr=0, ext_in=0, ext_sign=0, wait count=0.
- **States:** IDLE, REQ, EXT, DONE.
- **IDLE**
  - start=1 → latch addr into addr_q and sign into sign_q, clear the wait counter, go to REQ.
  - start=0 → stay.
- **REQ**
  - mem_rd=1; mem_addr is driven from addr_q.
  - Priority order:
    1. mem_err=1 → go to DONE with err_q=1.
    2. mem_stall=0 → capture mem_data into word_q, go to EXT.
    3. Otherwise increment the wait counter. When it reaches MAX_WAIT → go to DONE with err_q=1.
  - mem_rd stays high for every cycle spent in REQ.
- **EXT**
  - Byte select: ext_in = addr_q[0] ? word_q[15:8] : word_q[7:0] (little-endian).
  - ext_sign = sign_q.
  - Register ext_out into data_out; set err_q=0; go to DONE.
- **DONE**
  - done=1 and err=err_q for exactly one cycle; go to IDLE.
  - If err_q=1, data_out is loaded with 16'h0000 on entry to DONE.
- **Outside EXT:** ext_in and ext_sign hold 0.
- **start while busy:** ignored, no queuing; the requester must wait for done.
- **start in the DONE cycle:** also ignored; a new request is accepted in IDLE only.
- **Mid-operation rst:** immediately returns to IDLE with all outputs at reset values; no done is issued for the aborted request.

## Timing
- Start sampled at edge 0 → REQ in cycle 1.
- With no stall: EXT in cycle 2, done=1 in cycle 3.
- Total latency = 3 + (stall cycles) from the start edge to the done pulse.
- Timeout: done arrives in cycle 1 + MAX_WAIT + 1.
- mem_err: done with err=1 arrives the cycle after the error is seen.
- done never asserts on consecutive cycles; minimum 4 cycles between dones.
- Outputs are registered state decodes; no combinational path from start to mem_rd.
- The only combinational paths are ext_in/ext_sign → ext_out (external) → the data_out register input.

## Test plan
- **LB, odd address, no stall:** addr=16'h0101, sign=1, mem_data=16'h80FF → mem_addr=16'h0100, done in cycle 3, data_out=16'hFF80, err=0.
- **LBU, even address, 2-cycle stall:** addr=16'h0040, sign=0, mem_data=16'h1290 → mem_rd high for 3 cycles, done in cycle 5, data_out=16'h0090.
- **Timeout with MAX_WAIT=4:** mem_stall held at 1 → done=1, err=1 in cycle 6, data_out=16'h0000, then IDLE with busy=0.
- **mem_err on the second REQ cycle:** done=1, err=1 in the next cycle; data_out=16'h0000.
- **start pulsed in cycles 1–3 of an active request:** the second request is ignored; exactly one done; busy=0 after done.
- **rst asserted asynchronously while in REQ:** busy, mem_rd and done drop to 0 without waiting for a clock edge; the next start completes normally with latency 3.

Source files
------------

// File: rtl/byte_load_ctrl_if.sv
// Bundle of the requester, data-memory and byte-extender signals seen by byte_load_ctrl.
// master = controller view, slave = environment view.
interface byte_load_ctrl_if;
   logic        start;
   logic [15:0] addr;
   logic        sign;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] data_out;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_stall;
   logic        mem_err;
   logic [15:0] mem_data;
   logic [7:0]  ext_in;
   logic        ext_sign;
   logic [15:0] ext_out;

   modport master (
      input  start, addr, sign, mem_stall, mem_err, mem_data, ext_out,
      output busy, done, err, data_out, mem_rd, mem_addr, ext_in, ext_sign
   );

   modport slave (
      output start, addr, sign, mem_stall, mem_err, mem_data, ext_out,
      input  busy, done, err, data_out, mem_rd, mem_addr, ext_in, ext_sign
   );
endinterface

// File: rtl/byte_load_ctrl.sv
// Multi-cycle LB/LBU controller: aligned word read with stall/timeout handling,
// byte select into the shared extender, registered result with a one-cycle done.
module byte_load_ctrl #(
   parameter int MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   byte_load_ctrl_if.master bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_EXT  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   logic [1:0]  r_state;
   logic [15:0] r_addr;
   logic        r_sign;
   logic [15:0] r_word;
   logic [7:0]  r_wait;
   logic        r_err;
   logic [15:0] r_data;
   logic [7:0]  w_byte;

   // Little-endian: odd byte address selects the upper half of the word.
   assign w_byte = r_addr[0] ? r_word[15:8] : r_word[7:0];

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.err      = (r_state == S_DONE) && r_err;
   assign bus.data_out = r_data;
   assign bus.mem_rd   = (r_state == S_REQ);
   assign bus.mem_addr = {r_addr[15:1], 1'b0};
   assign bus.ext_in   = (r_state == S_EXT) ? w_byte : 8'h00;
   assign bus.ext_sign = (r_state == S_EXT) && r_sign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= 16'h0000;
         r_sign  <= 1'b0;
         r_word  <= 16'h0000;
         r_wait  <= 8'h00;
         r_err   <= 1'b0;
         r_data  <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr  <= bus.addr;
                  r_sign  <= bus.sign;
                  r_wait  <= 8'h00;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               // Timeout fires on the stall after MAX_WAIT tolerated ones.
               if (bus.mem_err) begin
                  r_err   <= 1'b1;
                  r_data  <= 16'h0000;
                  r_state <= S_DONE;
               end else if (!bus.mem_stall) begin
                  r_word  <= bus.mem_data;
                  r_state <= S_EXT;
               end else if (r_wait == LP_MAX_WAIT) begin
                  r_err   <= 1'b1;
                  r_data  <= 16'h0000;
                  r_state <= S_DONE;
               end else begin
                  r_wait <= r_wait + 8'h01;
               end
            end
            S_EXT: begin
               r_data  <= bus.ext_out;
               r_err   <= 1'b0;
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_load_ctrl.sv
// Self-checking bench for byte_load_ctrl: directed cases plus randomized loads
// compared against an outcome/latency model computed from the load rules.
module tb_byte_load_ctrl;
   localparam int MW = 4;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   byte_load_ctrl_if bus ();

   byte_load_ctrl #(.MAX_WAIT(MW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External 8-to-16 extender.
   assign bus.ext_out = bus.ext_sign ? {{8{bus.ext_in[7]}}, bus.ext_in} : {8'h00, bus.ext_in};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One load; nst = stalled REQ cycles, eat = REQ cycle index carrying mem_err (255 = none).
   task automatic run_txn(input logic [15:0] a, input bit s, input logic [15:0] w,
                          input int nst, input int eat, input bit pulse);
      int          byte_v;
      int          req_c;
      int          done_c;
      bit          exp_err;
      logic [15:0] exp_data;
      int          seen_c;
      int          n_done;
      logic        got_err;
      int          ext_exp;
      int          sgn_exp;
      byte_v = a[0] ? int'(w >> 8) : int'(w & 16'h00FF);
      if (eat <= nst && eat <= MW) begin
         exp_err = 1'b1; done_c = eat + 2; req_c = eat + 1; exp_data = 16'h0000;
      end else if (nst <= MW) begin
         exp_err = 1'b0; done_c = nst + 3; req_c = nst + 1;
         exp_data = (s && byte_v >= 128) ? 16'(byte_v + 16'hFF00) : 16'(byte_v);
      end else begin
         exp_err = 1'b1; done_c = MW + 2; req_c = MW + 1; exp_data = 16'h0000;
      end
      seen_c = 0; n_done = 0; got_err = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.addr = a; bus.sign = s; bus.mem_data = w;
      bus.mem_stall = 1'b0; bus.mem_err = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            n_done++;
            if (seen_c == 0) begin
               seen_c = c; got_err = bus.err;
            end
         end
         check("mem_rd", 32'(bus.mem_rd), 32'(c <= req_c));
         ext_exp = (!exp_err && c == nst + 2) ? byte_v : 0;
         sgn_exp = (!exp_err && c == nst + 2) ? int'(s) : 0;
         check("ext_in", 32'(bus.ext_in), 32'(ext_exp));
         check("ext_sign", 32'(bus.ext_sign), 32'(sgn_exp));
         if (c == 1) check("mem_addr", 32'(bus.mem_addr), 32'(a & 16'hFFFE));
         bus.mem_stall = (c - 1 < nst);
         bus.mem_err   = (c - 1 == eat);
         bus.start     = pulse && c <= 3 && c <= done_c;
      end
      bus.start = 1'b0; bus.mem_stall = 1'b0; bus.mem_err = 1'b0;
      check("done_cycle", 32'(seen_c), 32'(done_c));
      check("done_count", 32'(n_done), 32'd1);
      check("err", 32'(got_err), 32'(exp_err));
      check("data_out", 32'(bus.data_out), 32'(exp_data));
      check("busy_after", 32'(bus.busy), 32'd0);
      $display("txn addr=%h sign=%0d word=%h stall=%0d errat=%0d pulse=%0d -> done@%0d err=%0d data=%h",
               a, s, w, nst, eat, pulse, seen_c, got_err, bus.data_out);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.addr = 16'h0000; bus.sign = 1'b0;
      bus.mem_stall = 1'b0; bus.mem_err = 1'b0; bus.mem_data = 16'h0000;
      @(negedge clk); @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_ext_in", 32'(bus.ext_in), 32'd0);
      check("rst_ext_sign", 32'(bus.ext_sign), 32'd0);
      rst = 1'b0;

      run_txn(16'h0101, 1'b1, 16'h80FF, 0, 255, 1'b0);
      run_txn(16'h0040, 1'b0, 16'h1290, 2, 255, 1'b0);
      run_txn(16'h1234, 1'b1, 16'hABCD, 99, 255, 1'b0);
      run_txn(16'h0203, 1'b1, 16'h8001, 5, 1, 1'b0);
      run_txn(16'h0055, 1'b1, 16'h7F80, 1, 255, 1'b1);
      run_txn(16'h0ABC, 1'b1, 16'h00F0, 0, 255, 1'b1);

      // Asynchronous reset in the middle of REQ.
      @(negedge clk);
      bus.start = 1'b1; bus.addr = 16'h3333; bus.sign = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.mem_stall = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_data", 32'(bus.data_out), 32'd0);
      @(negedge clk);
      rst = 1'b0; bus.mem_stall = 1'b0;
      run_txn(16'h4445, 1'b0, 16'hC3A5, 0, 255, 1'b0);

      for (int k = 0; k < 40; k++) begin
         logic [15:0] ra;
         logic [15:0] rw;
         bit          rs;
         int          rn;
         int          re;
         bit          rp;
         ra = 16'($urandom);
         rw = 16'($urandom);
         rs = 1'($urandom);
         rn = int'($urandom_range(0, 6));
         re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 255;
         rp = 1'($urandom);
         run_txn(ra, rs, rw, rn, re, rp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
